// File: rtl/ff_share_sched.sv
// ff_share_sched: round-robin scheduler that time-shares one registered datapath stage
// among NUM_REQ requesters. It returns the sampled stage output to the winning requester
// and flags any difference between the data sent and the data received.
module ff_share_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LAT     = 1,
    localparam int unsigned IDW    = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         stage_d,
    input  logic [WIDTH-1:0]         stage_q,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_mismatch,
    input  logic                     rsp_ready,
    output logic [15:0]              err_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [4:0]       wcnt_q, wcnt_d;        // LAT+1 is at most 16
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] stage_d_q, stage_d_d;
    logic [WIDTH-1:0] sent_q, sent_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_mismatch_q, rsp_mismatch_d;
    logic [15:0]      err_count_q, err_count_d;

    logic             grant_any;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] win_data;

    // Round-robin search: first valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx_int;
        logic [IDW-1:0] idx;
        grant_any = 1'b0;
        win       = '0;
        idx_int   = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_int = (32'(ptr_q) + k) % NUM_REQ;
            idx     = IDW'(idx_int);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                win       = idx;
            end
        end
    end

    // Data lane of the current winner.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot accept, only offered while idle so a single transaction is ever in flight.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_any) begin
            req_ready[win] = 1'b1;
        end
    end

    // Next-state logic: grant in IDLE, count out the stage latency, hold the response.
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        ptr_d          = ptr_q;
        stage_d_d      = stage_d_q;
        sent_d         = sent_q;
        rsp_id_d       = rsp_id_q;
        rsp_data_d     = rsp_data_q;
        rsp_mismatch_d = rsp_mismatch_q;
        err_count_d    = err_count_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    state_d   = StWait;
                    wcnt_d    = 5'(LAT + 1);
                    ptr_d     = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
                    stage_d_d = win_data;
                    sent_d    = win_data;
                    rsp_id_d  = win;
                end
            end
            StWait: begin
                if (wcnt_q == 5'd1) begin
                    state_d        = StResp;
                    rsp_data_d     = stage_q;
                    rsp_mismatch_d = (stage_q != sent_q);
                    if ((stage_q != sent_q) && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end else begin
                    wcnt_d = wcnt_q - 5'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; an asynchronous reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            wcnt_q         <= '0;
            ptr_q          <= '0;
            stage_d_q      <= '0;
            sent_q         <= '0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
            rsp_mismatch_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            ptr_q          <= ptr_d;
            stage_d_q      <= stage_d_d;
            sent_q         <= sent_d;
            rsp_id_q       <= rsp_id_d;
            rsp_data_q     <= rsp_data_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            err_count_q    <= err_count_d;
        end
    end

    assign stage_d      = stage_d_q;
    assign rsp_valid    = (state_q == StResp);
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_ff_share_sched.sv
// Directed testbench for ff_share_sched with a one-flop shared stage model (LAT=1).
module tb_ff_share_sched;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned LAT     = 1;
    localparam int unsigned IDW     = 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         stage_d;
    logic [WIDTH-1:0]         stage_q;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_mismatch;
    logic                     rsp_ready;
    logic [15:0]              err_count;

    logic [WIDTH-1:0] stage_r;
    logic             inv;

    int n_cmp  = 0;
    int n_fail = 0;

    ff_share_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .stage_d      (stage_d),
        .stage_q      (stage_q),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_mismatch (rsp_mismatch),
        .rsp_ready    (rsp_ready),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Shared stage: a single d->q flop on the same reset, optionally inverting its output.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) stage_r <= '0;
        else          stage_r <= stage_d;
    end
    assign stage_q = inv ? ~stage_r : stage_r;

    // Requester rules: a pending request keeps valid high and its data stable.
    logic [NUM_REQ-1:0]       pend_q;
    logic [NUM_REQ*WIDTH-1:0] pend_data_q;
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend_q[i]) begin
                    assert (req_valid[i]) else $error("requester %0d dropped valid", i);
                    assert (req_data[i*WIDTH +: WIDTH] == pend_data_q[i*WIDTH +: WIDTH])
                        else $error("requester %0d changed data while pending", i);
                end
            end
        end
        pend_q      <= reset_n ? (req_valid & ~req_ready) : '0;
        pend_data_q <= req_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        inv       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        inv       = 1'b0;
        tick();
        tick();
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (stage_d !== 8'h00) begin n_fail++;
            $display("FAIL reset_stage_d: got %h want 00", stage_d); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data, rsp_mismatch} !== 12'h000) begin n_fail++;
            $display("FAIL reset_rsp: got v=%b id=%0d d=%h m=%b want all zero",
                     rsp_valid, rsp_id, rsp_data, rsp_mismatch); end
        n_cmp++; if (err_count !== 16'h0000) begin n_fail++;
            $display("FAIL reset_err_count: got %h want 0000", err_count); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 8'hA5;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++;
            $display("FAIL single_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (stage_d !== 8'hA5) begin n_fail++;
            $display("FAIL single_stage_d: got %h want a5", stage_d); end
        tick();
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data, rsp_mismatch} !== {1'b1, 2'd2, 8'hA5, 1'b0})
            begin n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d d=%h m=%b want v=1 id=2 d=a5 m=0",
                     rsp_valid, rsp_id, rsp_data, rsp_mismatch); end
        n_cmp++; if (err_count !== 16'h0000) begin n_fail++;
            $display("FAIL single_err_count: got %h want 0000", err_count); end
        tick();
        n_cmp++; if ({rsp_valid, stage_d} !== {1'b0, 8'hA5}) begin n_fail++;
            $display("FAIL single_after: got v=%b stage_d=%h want v=0 stage_d=a5",
                     rsp_valid, stage_d); end
    endtask

    task automatic test_round_robin();
        logic [3:0]       exp_rdy [5];
        logic [3:0]       g_rdy [5];
        int               g_cyc [5];
        logic [IDW-1:0]   r_id [4];
        logic [WIDTH-1:0] r_data [4];
        int               g_cnt;
        int               r_cnt;
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        g_cnt = 0;
        r_cnt = 0;
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 40 && g_cnt < 5; c++) begin
            if (req_ready != 4'b0000) begin
                g_rdy[g_cnt] = req_ready;
                g_cyc[g_cnt] = c;
                g_cnt++;
            end
            if (rsp_valid && r_cnt < 4) begin
                r_id[r_cnt]   = rsp_id;
                r_data[r_cnt] = rsp_data;
                r_cnt++;
            end
            if (g_cnt < 5) tick();
        end
        n_cmp++; if (g_cnt != 5 || r_cnt != 4) begin n_fail++;
            $display("FAIL rr_count: got %0d grants %0d rsps want 5 grants 4 rsps", g_cnt, r_cnt);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (g_rdy[i] !== exp_rdy[i]) begin n_fail++;
                    $display("FAIL rr_grant%0d: got %b want %b", i, g_rdy[i], exp_rdy[i]); end
            end
            for (int i = 1; i < 5; i++) begin
                n_cmp++; if (g_cyc[i] - g_cyc[i-1] != int'(LAT + 3)) begin n_fail++;
                    $display("FAIL rr_period%0d: got %0d want %0d", i,
                             g_cyc[i] - g_cyc[i-1], LAT + 3); end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if ({r_id[i], r_data[i]} !== {IDW'(i), 8'h10 + 8'(i)}) begin n_fail++;
                    $display("FAIL rr_rsp%0d: got id=%0d d=%h want id=%0d d=%h", i,
                             r_id[i], r_data[i], i, 8'h10 + 8'(i)); end
            end
        end
        do_reset();
    endtask

    task automatic test_mismatch();
        inv       = 1'b1;
        req_valid = 4'b0001;
        req_data[0 +: WIDTH] = 8'h3C;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++; if ({rsp_valid, rsp_data, rsp_mismatch} !== {1'b1, 8'hC3, 1'b1}) begin n_fail++;
            $display("FAIL mism_rsp: got v=%b d=%h m=%b want v=1 d=c3 m=1",
                     rsp_valid, rsp_data, rsp_mismatch); end
        n_cmp++; if (err_count !== 16'h0001) begin n_fail++;
            $display("FAIL mism_err_count: got %h want 0001", err_count); end
        tick();
        inv       = 1'b0;
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 8'h55;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data, rsp_mismatch} !== {1'b1, 2'd1, 8'h55, 1'b0})
            begin n_fail++;
            $display("FAIL mism_clean_rsp: got v=%b id=%0d d=%h m=%b want v=1 id=1 d=55 m=0",
                     rsp_valid, rsp_id, rsp_data, rsp_mismatch); end
        n_cmp++; if (err_count !== 16'h0001) begin n_fail++;
            $display("FAIL mism_clean_err: got %h want 0001", err_count); end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_data[0 +: WIDTH] = 8'h77;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL bp_grant0: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 8'h99;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL bp_wait_ready: got %b want 0000", req_ready); end
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_mismatch, req_ready}
                    !== {1'b1, 2'd0, 8'h77, 1'b0, 4'b0000}) begin n_fail++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d d=%h m=%b rdy=%b want 1 0 77 0 0000",
                         c, rsp_valid, rsp_id, rsp_data, rsp_mismatch, req_ready); end
        end
        tick();
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin n_fail++;
            $display("FAIL bp_release: got v=%b rdy=%b want v=1 rdy=0000", rsp_valid, req_ready);
        end
        tick();
        n_cmp++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin n_fail++;
            $display("FAIL bp_next_grant: got v=%b rdy=%b want v=0 rdy=0010",
                     rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'h99}) begin n_fail++;
            $display("FAIL bp_rsp1: got v=%b id=%0d d=%h want v=1 id=1 d=99",
                     rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw;
        req_valid = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 8'h5A;
        tick();
        req_valid = '0;
        n_cmp++; if (err_count !== 16'h0001) begin n_fail++;
            $display("FAIL rmid_pre_err: got %h want 0001", err_count); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({req_ready, stage_d, rsp_valid, rsp_id, rsp_data, rsp_mismatch, err_count}
                !== 32'h0) begin n_fail++;
            $display("FAIL rmid_async: got rdy=%b sd=%h v=%b id=%0d d=%h m=%b err=%h want all 0",
                     req_ready, stage_d, rsp_valid, rsp_id, rsp_data, rsp_mismatch, err_count);
        end
        tick();
        reset_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rsp_valid !== 1'b0) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++;
            $display("FAIL rmid_no_rsp: got rsp_valid seen=%b want 0", saw); end
        req_valid = 4'b1001;
        req_data[0 +: WIDTH]       = 8'h01;
        req_data[3*WIDTH +: WIDTH] = 8'h3E;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL rmid_ptr0: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b1000;
        tick();
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'h01}) begin n_fail++;
            $display("FAIL rmid_rsp0: got v=%b id=%0d d=%h want v=1 id=0 d=01",
                     rsp_valid, rsp_id, rsp_data); end
        tick();
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++;
            $display("FAIL rmid_grant3: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 8'h3E}) begin n_fail++;
            $display("FAIL rmid_rsp3: got v=%b id=%0d d=%h want v=1 id=3 d=3e",
                     rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_saturation();
        force dut.err_count_q = 16'hFFFE;
        tick();
        release dut.err_count_q;
        #1;
        n_cmp++; if (err_count !== 16'hFFFE) begin n_fail++;
            $display("FAIL sat_preload: got %h want fffe", err_count); end
        inv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0001;
            req_data[0 +: WIDTH] = 8'h0F + 8'(k);
            tick();
            req_valid = '0;
            tick();
            tick();
            n_cmp++; if ({rsp_valid, rsp_mismatch, err_count} !== {1'b1, 1'b1, 16'hFFFF}) begin
                n_fail++;
                $display("FAIL sat_err%0d: got v=%b m=%b err=%h want v=1 m=1 err=ffff",
                         k, rsp_valid, rsp_mismatch, err_count); end
            tick();
        end
        inv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mismatch();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
